// File: rtl/rob_commit_unit_pkg.sv
// Shared definitions for the reorder buffer: tag encoding, entry field widths
// and the tag-to-index mapping used by both the capture path and the query ports.
package rob_pkg;

  localparam logic [31:0] TAG_NONE = '0;
  localparam int unsigned RD_W     = 5;

  // Tags are index + 1 so that tag 0 can mean "no producer / no broadcast".
  function automatic logic [31:0] tag_to_idx(input logic [31:0] tag);
    return tag - 32'd1;
  endfunction

  function automatic logic tag_in_range(input logic [31:0] tag, input int unsigned depth);
    return (tag != TAG_NONE) && (tag <= depth);
  endfunction

endpackage

// File: rtl/rob_commit_unit_if.sv
// Issue / CDB / query / commit bundle of the reorder buffer.
// master = core side (issue, CDB, RAT, regfile); slave = the ROB.
interface rob_commit_unit_if
  import rob_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 8,
  parameter int XLEN  = 32
);
  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [RD_W-1:0]          alloc_rd;
  logic [XLEN-1:0]          alloc_pc;
  logic                     alloc_is_ctrl;
  logic [TAG_W-1:0]         alloc_tag;
  logic [TAG_W-1:0]         cdb_tag;
  logic [XLEN-1:0]          cdb_data;
  logic                     cdb_redirect;
  logic [XLEN-1:0]          cdb_target;
  logic [TAG_W-1:0]         q_tag_a;
  logic [TAG_W-1:0]         q_tag_b;
  logic                     q_ready_a;
  logic                     q_ready_b;
  logic [XLEN-1:0]          q_data_a;
  logic [XLEN-1:0]          q_data_b;
  logic                     commit_ready;
  logic                     commit_valid;
  logic [RD_W-1:0]          commit_rd;
  logic [XLEN-1:0]          commit_data;
  logic [TAG_W-1:0]         commit_tag;
  logic [XLEN-1:0]          commit_pc;
  logic                     flush;
  logic [XLEN-1:0]          redirect_pc;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output alloc_valid, alloc_rd, alloc_pc, alloc_is_ctrl,
    output cdb_tag, cdb_data, cdb_redirect, cdb_target,
    output q_tag_a, q_tag_b, commit_ready,
    input  alloc_ready, alloc_tag, q_ready_a, q_ready_b, q_data_a, q_data_b,
    input  commit_valid, commit_rd, commit_data, commit_tag, commit_pc,
    input  flush, redirect_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_pc, alloc_is_ctrl,
    input  cdb_tag, cdb_data, cdb_redirect, cdb_target,
    input  q_tag_a, q_tag_b, commit_ready,
    output alloc_ready, alloc_tag, q_ready_a, q_ready_b, q_data_a, q_data_b,
    output commit_valid, commit_rd, commit_data, commit_tag, commit_pc,
    output flush, redirect_pc, count
  );
endinterface

// File: rtl/rob_commit_unit_query_port.sv
// Source-operand lookup into the ROB by tag.
// Build option ROB_CDB_BYPASS_EN forwards a same-cycle CDB broadcast.
module rob_query_port
  import rob_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 8,
  parameter int XLEN  = 32
) (
  input  logic [TAG_W-1:0] q_tag,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] done,
  input  logic [XLEN-1:0]  entry_data [DEPTH],
`ifdef ROB_CDB_BYPASS_EN
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
`endif
  output logic             ready,
  output logic [XLEN-1:0]  q_data
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             in_range;
  logic [PTR_W-1:0] idx;

  always_comb begin
    in_range = tag_in_range(32'(q_tag), DEPTH);
    idx      = PTR_W'(tag_to_idx(32'(q_tag)));
    ready    = 1'b0;
    q_data   = '0;
    if (32'(q_tag) == TAG_NONE) begin
      ready = 1'b1;
    end else if (in_range && valid[idx] && done[idx]) begin
      ready  = 1'b1;
      q_data = entry_data[idx];
    end
`ifdef ROB_CDB_BYPASS_EN
    if (in_range && valid[idx] && (cdb_tag == q_tag)) begin
      ready  = 1'b1;
      q_data = cdb_data;
    end
`endif
  end
endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates at issue, captures CDB results, retires in order,
// squashes on a taken branch. Optional build macro: ROB_CDB_BYPASS_EN.
module rob_commit_unit
  import rob_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 8,
  parameter int XLEN  = 32
) (
  input logic             clk,
  input logic             rst_n,
  rob_commit_unit_if.slave rob
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned N     = DEPTH;

  logic [PTR_W-1:0] head, tail, cdb_idx;
  logic [CNT_W-1:0] cnt;
  logic [DEPTH-1:0] valid, done, is_ctrl, redirect;
  logic [RD_W-1:0]  rd_q     [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [XLEN-1:0]  data_q   [DEPTH];
  logic             alloc_fire, commit_fire, cdb_hit;

  always_comb begin
    rob.alloc_ready  = (cnt < CNT_W'(DEPTH));
    rob.alloc_tag    = TAG_W'(tail) + TAG_W'(1);
    rob.commit_valid = valid[head] & done[head];
    commit_fire      = rob.commit_valid & rob.commit_ready;
    rob.flush        = commit_fire & redirect[head];
    alloc_fire       = rob.alloc_valid & rob.alloc_ready & ~rob.flush;
    rob.commit_rd    = rd_q[head];
    rob.commit_data  = data_q[head];
    rob.commit_tag   = TAG_W'(head) + TAG_W'(1);
    rob.commit_pc    = pc_q[head];
    rob.redirect_pc  = target_q[head];
    rob.count        = cnt;
    cdb_idx          = PTR_W'(tag_to_idx(32'(rob.cdb_tag)));
    cdb_hit          = tag_in_range(32'(rob.cdb_tag), DEPTH) && valid[cdb_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      valid    <= '0;
      done     <= '0;
      is_ctrl  <= '0;
      redirect <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        target_q[i] <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      // Redirect only counts for entries issued as control flow.
      if (cdb_hit) begin
        done[cdb_idx]     <= 1'b1;
        data_q[cdb_idx]   <= rob.cdb_data;
        redirect[cdb_idx] <= rob.cdb_redirect & is_ctrl[cdb_idx];
        target_q[cdb_idx] <= rob.cdb_target;
      end
      if (alloc_fire) begin
        valid[tail]    <= 1'b1;
        done[tail]     <= 1'b0;
        redirect[tail] <= 1'b0;
        is_ctrl[tail]  <= rob.alloc_is_ctrl;
        rd_q[tail]     <= rob.alloc_rd;
        pc_q[tail]     <= rob.alloc_pc;
        tail           <= tail + PTR_W'(1);
      end
      if (commit_fire) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      // Flush overrides the per-entry updates above, dropping any same-cycle allocation.
      if (rob.flush) begin
        valid <= '0;
        done  <= '0;
        head  <= '0;
        tail  <= '0;
        cnt   <= '0;
      end else if (alloc_fire != commit_fire) begin
        cnt <= alloc_fire ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
      end
    end
  end

  rob_query_port #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) u_query_a (
    .q_tag      (rob.q_tag_a),
    .valid      (valid),
    .done       (done),
    .entry_data (data_q),
`ifdef ROB_CDB_BYPASS_EN
    .cdb_tag    (rob.cdb_tag),
    .cdb_data   (rob.cdb_data),
`endif
    .ready      (rob.q_ready_a),
    .q_data     (rob.q_data_a)
  );

  rob_query_port #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) u_query_b (
    .q_tag      (rob.q_tag_b),
    .valid      (valid),
    .done       (done),
    .entry_data (data_q),
`ifdef ROB_CDB_BYPASS_EN
    .cdb_tag    (rob.cdb_tag),
    .cdb_data   (rob.cdb_data),
`endif
    .ready      (rob.q_ready_b),
    .q_data     (rob.q_data_b)
  );
endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: expected retirements are queued at
// allocation and compared in order as the ROB commits.
module tb_rob_commit_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rob_commit_unit_if #(.DEPTH(8), .TAG_W(8), .XLEN(32)) rob_if ();

  rob_commit_unit #(.DEPTH(8), .TAG_W(8), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rob   (rob_if)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [7:0]  tag;
    logic [31:0] data;
    logic [31:0] pc;
    logic        fl;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_tail = 0;
  logic flush_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Commit monitor: every retirement must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rob_if.flush) flush_seen = 1'b1;
    if (rst_n && rob_if.commit_valid && rob_if.commit_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_commit_tag", rob_if.commit_tag, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("commit_rd",   rob_if.commit_rd,   e.rd);
        check_eq("commit_data", rob_if.commit_data, e.data);
        check_eq("commit_tag",  rob_if.commit_tag,  e.tag);
        check_eq("commit_pc",   rob_if.commit_pc,   e.pc);
        check_eq("commit_flush", rob_if.flush,      e.fl);
        if (e.fl) check_eq("redirect_pc", rob_if.redirect_pc, e.rpc);
      end
    end
  end

  task automatic do_alloc(input logic [4:0] rd, input logic is_ctrl, input logic [31:0] data,
                          input logic fl, input logic [31:0] rpc, input bit push);
    logic [7:0]  t;
    logic [31:0] pc;
    t  = 8'(exp_tail + 1);
    pc = 32'h1000 + 32'(t) * 4;
    rob_if.alloc_valid   = 1'b1;
    rob_if.alloc_rd      = rd;
    rob_if.alloc_pc      = pc;
    rob_if.alloc_is_ctrl = is_ctrl;
    #1 check_eq("alloc_tag", rob_if.alloc_tag, t);
    if (push) sb.push_back('{rd: rd, tag: t, data: data, pc: pc, fl: fl, rpc: rpc});
    @(posedge clk); #1;
    rob_if.alloc_valid   = 1'b0;
    rob_if.alloc_is_ctrl = 1'b0;
    exp_tail = (exp_tail + 1) % 8;
  endtask

  task automatic do_bcast(input logic [7:0] tag, input logic [31:0] data,
                          input logic redir, input logic [31:0] target);
    rob_if.cdb_tag      = tag;
    rob_if.cdb_data     = data;
    rob_if.cdb_redirect = redir;
    rob_if.cdb_target   = target;
    @(posedge clk); #1;
    rob_if.cdb_tag      = '0;
    rob_if.cdb_redirect = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rob_if.count == 0) break;
      @(posedge clk); #1;
    end
    check_eq("drain_count", rob_if.count, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1, t2, t3;
    rst_n = 1'b0;
    rob_if.alloc_valid = 0; rob_if.alloc_rd = '0; rob_if.alloc_pc = '0; rob_if.alloc_is_ctrl = 0;
    rob_if.cdb_tag = '0; rob_if.cdb_data = '0; rob_if.cdb_redirect = 0; rob_if.cdb_target = '0;
    rob_if.q_tag_a = '0; rob_if.q_tag_b = '0; rob_if.commit_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_count", rob_if.count, 0);
    check_eq("rst_alloc_ready", rob_if.alloc_ready, 1);
    check_eq("rst_commit_valid", rob_if.commit_valid, 0);
    check_eq("rst_flush", rob_if.flush, 0);
    check_eq("rst_commit_data", rob_if.commit_data, 0);
    check_eq("rst_alloc_tag", rob_if.alloc_tag, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill: tags 1..8, then full and a 9th request is refused
    for (int i = 1; i <= 8; i++) do_alloc(5'(i), 1'b0, 32'hD0 + 32'(i), 1'b0, '0, 1'b1);
    check_eq("full_count", rob_if.count, 8);
    check_eq("full_alloc_ready", rob_if.alloc_ready, 0);
    rob_if.alloc_valid = 1'b1; rob_if.alloc_rd = 5'd9;
    @(posedge clk); #1;
    rob_if.alloc_valid = 1'b0;
    check_eq("ninth_ignored_count", rob_if.count, 8);
    rob_if.commit_ready = 1'b1;
    for (int i = 1; i <= 8; i++) do_bcast(8'(i), 32'hD0 + 32'(i), 1'b0, '0);
    wait_drain(40);

    // Out-of-order writeback, in-order commit, one-cycle CDB-to-commit latency
    t1 = 8'(exp_tail + 1);
    do_alloc(5'd1, 1'b0, 32'h11, 1'b0, '0, 1'b1);
    t2 = 8'(exp_tail + 1);
    do_alloc(5'd2, 1'b0, 32'h22, 1'b0, '0, 1'b1);
    do_bcast(t2, 32'h22, 1'b0, '0);
    check_eq("head_not_done", rob_if.commit_valid, 0);
    rob_if.cdb_tag = t1; rob_if.cdb_data = 32'h11;
    #1 check_eq("cdb_commit_latency", rob_if.commit_valid, 0);
    @(posedge clk); #1;
    rob_if.cdb_tag = '0;
    wait_drain(20);

    // Taken branch in the middle: younger entry squashed
    rob_if.commit_ready = 1'b0;
    t1 = 8'(exp_tail + 1);
    do_alloc(5'd3, 1'b0, 32'h31, 1'b0, '0, 1'b1);
    t2 = 8'(exp_tail + 1);
    do_alloc(5'd1, 1'b1, 32'h32, 1'b1, 32'h100, 1'b1);
    t3 = 8'(exp_tail + 1);
    do_alloc(5'd5, 1'b0, 32'h33, 1'b0, '0, 1'b0);
    do_bcast(t2, 32'h32, 1'b1, 32'h100);
    do_bcast(t1, 32'h31, 1'b0, '0);
    do_bcast(t3, 32'h33, 1'b0, '0);
    check_eq("pre_flush_count", rob_if.count, 3);
    rob_if.commit_ready = 1'b1;
    wait_drain(20);
    exp_tail = 0;
    check_eq("post_flush_commit_valid", rob_if.commit_valid, 0);
    check_eq("post_flush_sb_empty", sb.size(), 0);

    // Full ROB, head done: commit and alloc in the same cycle
    rob_if.commit_ready = 1'b0;
    for (int i = 1; i <= 8; i++) do_alloc(5'(i + 8), 1'b0, 32'h40 + 32'(i), 1'b0, '0, 1'b1);
    do_bcast(8'd1, 32'h41, 1'b0, '0);
    rob_if.alloc_valid = 1'b1; rob_if.alloc_rd = 5'd20;
    rob_if.commit_ready = 1'b1;
    #1;
    check_eq("full_commit_alloc_ready", rob_if.alloc_ready, 0);
    check_eq("full_commit_valid", rob_if.commit_valid, 1);
    @(posedge clk); #1;
    rob_if.alloc_valid = 1'b0; rob_if.commit_ready = 1'b0;
    check_eq("full_commit_count", rob_if.count, 7);
    rob_if.commit_ready = 1'b1;
    for (int i = 2; i <= 8; i++) do_bcast(8'(i), 32'h40 + 32'(i), 1'b0, '0);
    wait_drain(30);

    // Source queries, with and without same-cycle bypass
    rob_if.commit_ready = 1'b0;
    t1 = 8'(exp_tail + 1);
    do_alloc(5'd4, 1'b0, 32'h51, 1'b0, '0, 1'b1);
    t2 = 8'(exp_tail + 1);
    do_alloc(5'd6, 1'b0, 32'h52, 1'b0, '0, 1'b1);
    t3 = 8'(exp_tail + 1);
    do_alloc(5'd7, 1'b0, 32'hAB, 1'b0, '0, 1'b1);
    rob_if.cdb_tag = t3; rob_if.cdb_data = 32'hAB;
    rob_if.q_tag_a = t3; rob_if.q_tag_b = '0;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check_eq("bypass_ready_a", rob_if.q_ready_a, 1);
    check_eq("bypass_data_a", rob_if.q_data_a, 32'hAB);
`else
    check_eq("nobypass_ready_a", rob_if.q_ready_a, 0);
`endif
    check_eq("tag0_ready_b", rob_if.q_ready_b, 1);
    check_eq("tag0_data_b", rob_if.q_data_b, 0);
    @(posedge clk); #1;
    rob_if.cdb_tag = '0;
    rob_if.q_tag_b = t1;
    #1;
    check_eq("done_ready_a", rob_if.q_ready_a, 1);
    check_eq("done_data_a", rob_if.q_data_a, 32'hAB);
    check_eq("pending_ready_b", rob_if.q_ready_b, 0);
    rob_if.q_tag_a = '0; rob_if.q_tag_b = '0;
    rob_if.commit_ready = 1'b1;
    do_bcast(t1, 32'h51, 1'b0, '0);
    do_bcast(t2, 32'h52, 1'b0, '0);
    wait_drain(20);

    // Asynchronous reset with 5 entries outstanding
    rob_if.commit_ready = 1'b0;
    flush_seen = 1'b0;
    t1 = 8'(exp_tail + 1);
    for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 1'b0, '0, 1'b0, '0, 1'b0);
    do_bcast(t1, 32'h99, 1'b0, '0);
    check_eq("pre_reset_count", rob_if.count, 5);
    check_eq("pre_reset_commit_valid", rob_if.commit_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_reset_count", rob_if.count, 0);
    check_eq("mid_reset_commit_valid", rob_if.commit_valid, 0);
    check_eq("mid_reset_alloc_ready", rob_if.alloc_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_tail = 0;
    do_bcast(8'd4, 32'hEE, 1'b0, '0);
    rob_if.q_tag_a = 8'd4;
    #1;
    check_eq("stale_bcast_count", rob_if.count, 0);
    check_eq("stale_bcast_commit_valid", rob_if.commit_valid, 0);
    check_eq("stale_bcast_query", rob_if.q_ready_a, 0);
    check_eq("reset_no_flush", flush_seen, 0);
    rob_if.q_tag_a = '0;
    do_alloc(5'd7, 1'b0, 32'h77, 1'b0, '0, 1'b1);
    rob_if.commit_ready = 1'b1;
    do_bcast(8'd1, 32'h77, 1'b0, '0);
    wait_drain(20);

    check_eq("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
